bit_population_counter: RTL and testbench
=========================================

// Module: bit_population_counter
// PURPOSE
//  Counts the set bits (population count) of a WIDTH-bit input word.
//  Multi-cycle: one word is captured, then processed CHUNK_WIDTH bits per clock.
//  One result pulse is produced per accepted word.
//  Sits on a valid-only stream: there is no back-pressure, and words offered while busy are dropped.
// PARAMETERS
//  WIDTH        8  input word width, >=1
//  CHUNK_WIDTH  2  bits counted per clock, 1..WIDTH; N = ceil(WIDTH/CHUNK_WIDTH) count cycles
// PORTS
//  clk_i       in   1                single clock, all logic on posedge
//  srst_i      in   1                reset, asynchronous, active-high
//  data_i      in   WIDTH            word to count
//  data_val_i  in   1                data_i valid; sampled only when idle
//  data_o      out  $clog2(WIDTH)+1  popcount of last accepted word (range 0..WIDTH)
//  data_val_o  out  1                one-cycle pulse: data_o updated
// BEHAVIOUR
//  - Reset: srst_i high asynchronously forces state IDLE.
//    It also clears data_o=0, data_val_o=0, shift register, accumulator and chunk counter.
//  - Reset mid-COUNT aborts the word; no result pulse is produced for it.
//  - FSM states: IDLE, COUNT.
//  - IDLE, edge k with data_val_i=1:
//    - shift_reg <= data_i, zero-padded to N*CHUNK_WIDTH bits;
//    - acc <= 0, cnt <= 0, state goes to COUNT.
//  - IDLE with data_val_i=0: no change.
//  - COUNT edge:
//    - acc <= acc + popcount(shift_reg[CHUNK_WIDTH-1:0]);
//    - shift_reg >>= CHUNK_WIDTH;
//    - cnt++.
//  - COUNT edge with cnt==N-1 (last chunk):
//    - data_o <= acc + popcount(low chunk);
//    - data_val_o <= 1; state goes to IDLE.
//  - Latency: word accepted at edge k gives data_val_o high in the cycle after edge k+N.
//    With defaults that is 4 cycles.
//  - data_val_o is high for exactly one cycle.
//  - data_o holds its value until the next result (or reset).
//  - data_val_i and data_i at edges k+1..k+N are ignored: no queueing, no error flag.
//  - The word may change while busy; the captured copy is used.
//  - Back-to-back: the cycle with data_val_o=1 is IDLE.
//    data_val_i=1 in that cycle is accepted at edge k+N+1.
//    Throughput is one word per N+1 cycles.
//  - Width: acc and data_o are $clog2(WIDTH)+1 bits. The all-ones word gives WIDTH with no overflow.
//  - Padding bits beyond WIDTH are always 0 and never counted.
//  - data_i/data_val_i X while idle and not valid must not corrupt state.
// TESTING (WIDTH=8, CHUNK_WIDTH=2 unless noted)
//  1. Reset for 1 cycle, then data_i=14, data_val_i=1:
//     data_o=3, data_val_o pulse 1 cycle, 4 cycles after accept.
//  2. Same as 1, plus data_i=1 held valid the cycle after accept (busy):
//     no extra pulse; data_o stays 3.
//  3. data_i=0 valid 1 cycle: pulse with data_o=0.
//  4. data_i=8'hFF valid 1 cycle: pulse with data_o=8 (4'b1000).
//  5. data_val_i held high with data_i = 8'h01, 8'h03, ... per cycle:
//     one word accepted every 5 cycles; each result matches the word present at its accept edge.
//  6. Assert srst_i asynchronously 2 cycles after accepting 8'hF0:
//     outputs 0 immediately, no pulse.
//     Next word 8'h81 gives data_o=2.
//     Also, WIDTH=7, CHUNK_WIDTH=2, data_i=7'h7F gives data_o=7 after 4 cycles.

Source files
------------

// File: rtl/bit_population_counter.sv
// bit_population_counter: multi-cycle popcount, CHUNK_WIDTH bits per clock, drops words offered while busy
module bit_population_counter #(
  parameter int WIDTH       = 8,
  parameter int CHUNK_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   data_val_i,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o
);
  localparam int N  = (WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PW = N * CHUNK_WIDTH;
  localparam int OW = $clog2(WIDTH) + 1;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, COUNT} state_t;
  state_t          state;
  logic [PW-1:0]   shift_reg;
  logic [OW-1:0]   acc;
  logic [OW-1:0]   chunk_pop;
  logic [CW-1:0]   cnt;
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) chunk_pop = chunk_pop + OW'(shift_reg[i]);
  end
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state      <= IDLE;
      shift_reg  <= '0;
      acc        <= '0;
      cnt        <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= 1'b0;
      if (state == IDLE) begin
        if (data_val_i) begin
          shift_reg <= PW'(data_i);
          acc       <= '0;
          cnt       <= '0;
          state     <= COUNT;
        end
      end else begin
        acc       <= acc + chunk_pop;
        shift_reg <= shift_reg >> CHUNK_WIDTH;
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          data_o     <= acc + chunk_pop;
          data_val_o <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_population_counter.sv
// tb_bit_population_counter: scoreboard bench for 8/2 and 7/2 popcount instances driven in lock-step
module tb_bit_population_counter;
  localparam int N = 4;
  logic       clk_i = 1'b0;
  logic       srst_i = 1'b1;
  logic       data_val_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [3:0] data_o, data7_o;
  logic       data_val_o, data7_val_o;
  bit_population_counter #(.WIDTH(8), .CHUNK_WIDTH(2)) dut8 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_o(data_o), .data_val_o(data_val_o));
  bit_population_counter #(.WIDTH(7), .CHUNK_WIDTH(2)) dut7 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i[6:0]), .data_val_i(data_val_i),
    .data_o(data7_o), .data_val_o(data7_val_o));
  always #5 clk_i = ~clk_i;
  int edge_n = 0;
  always @(posedge clk_i) edge_n <= edge_n + 1;
  typedef struct {int at; logic [3:0] e8; logic [3:0] e7;} exp_t;
  exp_t       q[$];
  exp_t       x;
  int         next_free = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] last8 = '0, last7 = '0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, req, edge_n);
    end
  endtask
  // the model accepts a word only once the previous one has had N count cycles plus its idle result cycle
  task automatic drive(bit v, logic [7:0] d);
    @(negedge clk_i);
    data_val_i = v;
    data_i = d;
    if (v && edge_n + 1 >= next_free) begin
      q.push_back('{edge_n + 1 + N, 4'($countones(d)), 4'($countones(d[6:0]))});
      next_free = edge_n + 1 + N + 1;
    end
  endtask
  task automatic mid_reset();
    @(negedge clk_i);
    data_val_i = 1'b0;
    #2 srst_i = 1'b1;
    q.delete();
    next_free = 0;
    last8 = '0;
    last7 = '0;
    #1;
    chk("rst_data8", data_o, 0);
    chk("rst_val8", data_val_o, 0);
    chk("rst_data7", data7_o, 0);
    chk("rst_val7", data7_val_o, 0);
    @(negedge clk_i);
    #1 srst_i = 1'b0;
  endtask
  always @(negedge clk_i) if (!srst_i) begin
    if (data_val_o || data7_val_o) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got data_o=%0d data7_o=%0d expected no pulse at edge %0d", data_o, data7_o, edge_n);
      end else begin
        x = q.pop_front();
        chk("latency", edge_n, x.at);
        chk("val8", data_val_o, 1);
        chk("val7", data7_val_o, 1);
        chk("pop8", data_o, x.e8);
        chk("pop7", data7_o, x.e7);
        last8 = x.e8;
        last7 = x.e7;
      end
    end else begin
      chk("hold8", data_o, last8);
      chk("hold7", data7_o, last7);
      if (q.size() > 0 && q[0].at < edge_n) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_pulse: got none expected pulse at edge %0d", q[0].at);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    logic [7:0] d;
    repeat (2) @(negedge clk_i);
    #1;
    chk("init_data8", data_o, 0);
    chk("init_val8", data_val_o, 0);
    srst_i = 1'b0;
    drive(1, 8'd14);
    drive(1, 8'd1);
    repeat (6) drive(0, 'x);
    drive(1, 8'h00);
    repeat (5) drive(0, 'x);
    drive(1, 8'hFF);
    repeat (5) drive(0, 'x);
    drive(1, 8'h7F);
    repeat (5) drive(0, 'x);
    d = 8'h01;
    repeat (20) begin
      drive(1, d);
      d = {d[6:0], ~d[7]};
    end
    repeat (5) drive(0, 'x);
    drive(1, 8'hF0);
    drive(0, 8'h00);
    drive(0, 8'h00);
    mid_reset();
    drive(1, 8'h81);
    repeat (5) drive(0, 'x);
    repeat (400) drive($urandom_range(0, 3) != 0, 8'($urandom));
    repeat (N + 3) drive(0, 'x);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
